// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode and controller state encodings.
package seq_alu_pkg;

   localparam int OPCODE_W = 3;

   typedef enum logic [OPCODE_W-1:0] {
      OP_ADD   = 3'd0,
      OP_SUB   = 3'd1,
      OP_AND   = 3'd2,
      OP_OR    = 3'd3,
      OP_XOR   = 3'd4,
      OP_MUL   = 3'd5,
      OP_DIV   = 3'd6,
      OP_CMPEQ = 3'd7
   } opcode_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle,
// sharing a single 2*WIDTH accumulator and iteration counter.
module seq_alu_muldiv #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi
);

   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] acc_next_s;
   logic [WIDTH-1:0]   opb_r;
   logic               div_r;
   logic               busy_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH:0]     add_s;
   logic [WIDTH:0]     trial_s;

   // One step: multiplier consumes acc LSB; divider shifts in the next dividend bit
   always_comb begin
      add_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
      trial_s    = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opb_r};
      acc_next_s = acc_r;
      if (div_r) begin
         if (trial_s[WIDTH]) begin
            acc_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
         end else begin
            acc_next_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
         end
      end else begin
         if (acc_r[0]) begin
            acc_next_s = {add_s, acc_r[WIDTH-1:1]};
         end else begin
            acc_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r  <= '0;
         opb_r  <= '0;
         div_r  <= 1'b0;
         busy_r <= 1'b0;
         cnt_r  <= '0;
      end else if (start) begin
         acc_r  <= {{WIDTH{1'b0}}, a};
         opb_r  <= b;
         div_r  <= is_div;
         busy_r <= 1'b1;
         cnt_r  <= CNT_W'(WIDTH);
      end else if (busy_r) begin
         acc_r  <= acc_next_s;
         cnt_r  <= cnt_r - CNT_W'(1);
         busy_r <= (cnt_r != CNT_W'(1));
      end else begin
         acc_r  <= acc_r;
         busy_r <= 1'b0;
      end
   end

   // The final step's result is handed out combinationally so the owner captures it on the same edge.
   assign busy   = busy_r;
   assign done   = busy_r && (cnt_r == CNT_W'(1));
   assign res_lo = acc_next_s[WIDTH-1:0];
   assign res_hi = acc_next_s[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with valid/ready handshakes and registered flags.
// Optional signed-overflow flag output enabled by defining SEQ_ALU_OVF_EN.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    result_lo,
   output logic [WIDTH-1:0]    result_hi,
   output logic                carry,
   output logic                zero,
   output logic                dbz
`ifdef SEQ_ALU_OVF_EN
   ,
   output logic                ovf
`endif
);

   state_t           state_r, state_next_s;
   opcode_t          op_s;
   logic             load_s, start_s, finish_s;
   logic             in_ready_r, out_valid_r;
   logic [WIDTH:0]   sum_s, diff_s;
   logic [WIDTH-1:0] alu_lo_s, alu_hi_s, cap_lo_s, cap_hi_s;
   logic             alu_c_s, alu_dbz_s, cap_c_s, cap_dbz_s;
   logic [WIDTH-1:0] result_lo_r, result_hi_r;
   logic             carry_r, zero_r, dbz_r;
   logic             mdu_busy, mdu_done;
   logic [WIDTH-1:0] mdu_lo, mdu_hi;

   assign op_s = opcode_t'(opcode);

   seq_alu_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (start_s),
      .is_div (op_s == OP_DIV),
      .a      (a),
      .b      (b),
      .busy   (mdu_busy),
      .done   (mdu_done),
      .res_lo (mdu_lo),
      .res_hi (mdu_hi)
   );

   always_comb begin
      state_next_s = state_r;
      load_s       = 1'b0;
      start_s      = 1'b0;
      finish_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               if ((op_s == OP_MUL) || ((op_s == OP_DIV) && (b != '0))) begin
                  start_s      = 1'b1;
                  state_next_s = ST_ITER;
               end else begin
                  load_s       = 1'b1;
                  state_next_s = ST_DONE;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ITER: begin
            if (mdu_busy && mdu_done) begin
               finish_s     = 1'b1;
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_ITER;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next_s = ST_IDLE;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         in_ready_r  <= (state_next_s == ST_IDLE);
         out_valid_r <= (state_next_s == ST_DONE);
      end
   end

   // Single-cycle results; DIV here only covers the divide-by-zero case.
   always_comb begin
      sum_s     = {1'b0, a} + {1'b0, b};
      diff_s    = {1'b0, a} - {1'b0, b};
      alu_lo_s  = '0;
      alu_hi_s  = '0;
      alu_c_s   = 1'b0;
      alu_dbz_s = 1'b0;
      case (op_s)
         OP_ADD: begin
            alu_lo_s = sum_s[WIDTH-1:0];
            alu_c_s  = sum_s[WIDTH];
         end
         OP_SUB: begin
            alu_lo_s = diff_s[WIDTH-1:0];
            alu_c_s  = diff_s[WIDTH];
         end
         OP_AND:   alu_lo_s = a & b;
         OP_OR:    alu_lo_s = a | b;
         OP_XOR:   alu_lo_s = a ^ b;
         OP_CMPEQ: alu_lo_s = {{(WIDTH-1){1'b0}}, (a == b)};
         OP_DIV: begin
            alu_hi_s  = a;
            alu_dbz_s = 1'b1;
         end
         OP_MUL:   alu_lo_s = '0;
         default:  alu_lo_s = '0;
      endcase
   end

   always_comb begin
      cap_lo_s  = alu_lo_s;
      cap_hi_s  = alu_hi_s;
      cap_c_s   = alu_c_s;
      cap_dbz_s = alu_dbz_s;
      if (finish_s) begin
         cap_lo_s  = mdu_lo;
         cap_hi_s  = mdu_hi;
         cap_c_s   = 1'b0;
         cap_dbz_s = 1'b0;
      end else begin
         cap_lo_s  = alu_lo_s;
         cap_hi_s  = alu_hi_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_lo_r <= '0;
         result_hi_r <= '0;
         carry_r     <= 1'b0;
         zero_r      <= 1'b0;
         dbz_r       <= 1'b0;
      end else if (load_s || finish_s) begin
         result_lo_r <= cap_lo_s;
         result_hi_r <= cap_hi_s;
         carry_r     <= cap_c_s;
         zero_r      <= ({cap_hi_s, cap_lo_s} == '0);
         dbz_r       <= cap_dbz_s;
      end else begin
         result_lo_r <= result_lo_r;
      end
   end

`ifdef SEQ_ALU_OVF_EN
   logic alu_ovf_s;
   logic ovf_r;

   always_comb begin
      alu_ovf_s = 1'b0;
      case (op_s)
         OP_ADD:  alu_ovf_s = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
         OP_SUB:  alu_ovf_s = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
         default: alu_ovf_s = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (load_s) begin
         ovf_r <= alu_ovf_s;
      end else if (finish_s) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf = ovf_r;
`endif

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result_lo = result_lo_r;
   assign result_hi = result_hi_r;
   assign carry     = carry_r;
   assign zero      = zero_r;
   assign dbz       = dbz_r;

endmodule
